// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel pipeline: colour struct, cell code,
// board dimension, the 16-entry cell palette and the grid-line colour.
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef logic [3:0] cell_t;

  localparam int MATRIX_N = 10;

  localparam rgb_t GRID_RGB = rgb_t'(24'h606060);

  // Codes 8..15 are reserved and render as mid grey.
  localparam rgb_t PALETTE [16] = '{
    rgb_t'(24'h000000), rgb_t'(24'hFF0000), rgb_t'(24'h00FF00), rgb_t'(24'h0000FF),
    rgb_t'(24'hFFFF00), rgb_t'(24'h00FFFF), rgb_t'(24'hFF00FF), rgb_t'(24'hFFFFFF),
    rgb_t'(24'h808080), rgb_t'(24'h808080), rgb_t'(24'h808080), rgb_t'(24'h808080),
    rgb_t'(24'h808080), rgb_t'(24'h808080), rgb_t'(24'h808080), rgb_t'(24'h808080)
  };

endpackage

// File: rtl/matrix_renderer_if.sv
// Pixel-side bundle between the VGA timing/matrix sources (master) and the
// renderer (slave): coordinates, syncs and cell matrix in, RGB and delayed syncs out.
interface matrix_renderer_if;
  import vga_pkg::*;

  logic                                  pix_en;
  logic [9:0]                            pixel_x;
  logic [9:0]                            pixel_y;
  logic                                  video_on;
  logic                                  hsync_in;
  logic                                  vsync_in;
  cell_t [MATRIX_N-1:0][MATRIX_N-1:0]    matriz;
  logic [7:0]                            red;
  logic [7:0]                            green;
  logic [7:0]                            blue;
  logic                                  hsync;
  logic                                  vsync;

  modport master (
    output pix_en, pixel_x, pixel_y, video_on, hsync_in, vsync_in, matriz,
    input  red, green, blue, hsync, vsync
  );

  modport slave (
    input  pix_en, pixel_x, pixel_y, video_on, hsync_in, vsync_in, matriz,
    output red, green, blue, hsync, vsync
  );
endinterface

// File: rtl/cell_tracker.sv
// Division-free cell locator along one axis: tracks which cell (idx) and which
// pixel within that cell (sub) the last enabled position fell in.
module cell_tracker #(
  parameter int ORIGIN = 0,
  parameter int CELL   = 40,
  parameter int N      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [9:0] pos_i,
  output logic [3:0] idx_o,
  output logic [5:0] sub_o,
  output logic       inside_o
);

  localparam logic [9:0] LO       = 10'(ORIGIN);
  localparam logic [9:0] HI       = 10'(ORIGIN + N * CELL);
  localparam logic [5:0] LAST_SUB = 6'(CELL - 1);

  logic [3:0] idx_q, idx_d;
  logic [5:0] sub_q, sub_d;

  assign inside_o = (pos_i >= LO) && (pos_i < HI);
  assign idx_o    = idx_q;
  assign sub_o    = sub_q;

  // Reload at the window origin, otherwise step through the cell while inside.
  always_comb begin
    idx_d = idx_q;
    sub_d = sub_q;
    if (!en_i) begin
      idx_d = idx_q;
      sub_d = sub_q;
    end else if (pos_i == LO) begin
      idx_d = 4'd0;
      sub_d = 6'd0;
    end else if (inside_o && (sub_q == LAST_SUB)) begin
      idx_d = idx_q + 4'd1;
      sub_d = 6'd0;
    end else if (inside_o) begin
      sub_d = sub_q + 6'd1;
    end else begin
      idx_d = idx_q;
      sub_d = sub_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 4'd0;
      sub_q <= 6'd0;
    end else begin
      idx_q <= idx_d;
      sub_q <= sub_d;
    end
  end

endmodule

// File: rtl/matrix_renderer_chk.sv
// Guards the renderer's cell indices: an on-board pixel must never map past cell 9.
module matrix_renderer_chk (
  input logic       clk,
  input logic       rst,
  input logic       in_board_i,
  input logic [3:0] col_idx_i,
  input logic [3:0] row_idx_i
);

  a_idx_in_range: assert property (@(posedge clk) disable iff (rst)
    in_board_i |-> ((col_idx_i < 4'd10) && (row_idx_i < 4'd10)));

endmodule

// File: rtl/matrix_renderer.sv
// Maps VGA pixels onto the 10x10 cell board and emits palette RGB plus syncs,
// both with a fixed 2 pix_en latency. Define GRID_LINES_EN to overlay cell borders.
module matrix_renderer
  import vga_pkg::*;
#(
  parameter int          X0     = 120,
  parameter int          Y0     = 40,
  parameter int          CELL   = 40,
  parameter logic [23:0] BG_RGB = 24'h202020
) (
  input logic               clk,
  input logic               rst,
  matrix_renderer_if.slave  bus
);

  logic [3:0] col_idx_s, row_idx_s;
  logic [5:0] sub_x_s, sub_y_s;
  logic       x_inside_s, y_inside_s;
  logic       in_board_d;
  logic       in_board_q, video_on_q, hsync1_q, vsync1_q;
  logic       idx_bad_s, grid_s;
  cell_t      cell_s;
  rgb_t       rgb_d, rgb_q;
  logic       hsync_q, vsync_q;

  // Tracker registers double as the stage-1 column/row indices.
  cell_tracker #(.ORIGIN(X0), .CELL(CELL), .N(MATRIX_N)) u_x (
    .clk(clk), .rst(rst), .en_i(bus.pix_en), .pos_i(bus.pixel_x),
    .idx_o(col_idx_s), .sub_o(sub_x_s), .inside_o(x_inside_s)
  );

  cell_tracker #(.ORIGIN(Y0), .CELL(CELL), .N(MATRIX_N)) u_y (
    .clk(clk), .rst(rst), .en_i(bus.pix_en && (bus.pixel_x == 10'd0)), .pos_i(bus.pixel_y),
    .idx_o(row_idx_s), .sub_o(sub_y_s), .inside_o(y_inside_s)
  );

  assign in_board_d = bus.video_on && x_inside_s && y_inside_s;
  assign idx_bad_s  = (col_idx_s >= 4'(MATRIX_N)) || (row_idx_s >= 4'(MATRIX_N)) ||
                      (sub_x_s >= 6'(CELL)) || (sub_y_s >= 6'(CELL));
  assign cell_s     = idx_bad_s ? 4'd0 : bus.matriz[row_idx_s][col_idx_s];

`ifdef GRID_LINES_EN
  assign grid_s = (sub_x_s == 6'd0) || (sub_y_s == 6'd0) ||
                  ((col_idx_s == 4'(MATRIX_N - 1)) && (sub_x_s == 6'(CELL - 1))) ||
                  ((row_idx_s == 4'(MATRIX_N - 1)) && (sub_y_s == 6'(CELL - 1)));
`else
  assign grid_s = 1'b0;
`endif

  // Stage-2 colour select; an out-of-range index falls back to background.
  always_comb begin
    rgb_d = rgb_t'(24'h000000);
    if (!video_on_q) begin
      rgb_d = rgb_t'(24'h000000);
    end else if (!in_board_q || idx_bad_s) begin
      rgb_d = rgb_t'(BG_RGB);
    end else if (grid_s) begin
      rgb_d = GRID_RGB;
    end else begin
      rgb_d = PALETTE[cell_s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_board_q <= 1'b0;
      video_on_q <= 1'b0;
      hsync1_q   <= 1'b1;
      vsync1_q   <= 1'b1;
      rgb_q      <= rgb_t'(24'h000000);
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else if (bus.pix_en) begin
      in_board_q <= in_board_d;
      video_on_q <= bus.video_on;
      hsync1_q   <= bus.hsync_in;
      vsync1_q   <= bus.vsync_in;
      rgb_q      <= rgb_d;
      hsync_q    <= hsync1_q;
      vsync_q    <= vsync1_q;
    end
  end

  assign bus.red   = rgb_q.r;
  assign bus.green = rgb_q.g;
  assign bus.blue  = rgb_q.b;
  assign bus.hsync = hsync_q;
  assign bus.vsync = vsync_q;

  matrix_renderer_chk u_chk (
    .clk(clk), .rst(rst), .in_board_i(in_board_q),
    .col_idx_i(col_idx_s), .row_idx_i(row_idx_s)
  );

endmodule
